icache_sa_refill: RTL

//  N-way set-associative instruction cache between IF and the memory arbiter; successor to the 2-way icache.

---
 rtl/icache_sa_refill.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/icache_sa_refill.sv
// icache_sa_refill: N-way set-associative I-cache, multi-beat line refill, first-invalid/round-robin victim.
// Latency: hit word registered 1 cycle after lookup; a miss costs NBEAT memory replies plus one re-lookup cycle.
// Backpressure: stallreq held while a miss is pending (ce=1); each beat waits on cache_rep_i. Optional ICACHE_STATS_EN adds hit/miss counters.
module icache_sa_refill #(
  parameter int WORD_SELECT_BIT = 4,
  parameter int INDEX_BIT       = 4,
  parameter int NASSOC          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] addr,
  input  logic        read_flag,
  output logic [31:0] read_data,
  output logic        stallreq,
  input  logic        flush_i,
  output logic        cache_req_o,
  output logic [31:0] cache_addr_o,
  input  logic        cache_rep_i,
  input  logic [63:0] cache_rep_data_i
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);
  localparam int NBEAT   = 1 << (WORD_SELECT_BIT - 3);
  localparam int LINE_W  = 64 * NBEAT;
  localparam int NBLOCK  = 1 << INDEX_BIT;
  localparam int TAG_BIT = 32 - INDEX_BIT - WORD_SELECT_BIT;
  localparam int WAY_W   = (NASSOC > 1) ? $clog2(NASSOC) : 1;
  localparam int BEAT_W  = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int OFS_W   = WORD_SELECT_BIT - 2;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_REFILL = 1'b1;

  logic [TAG_BIT-1:0] tag_arr  [NASSOC][NBLOCK];
  logic [LINE_W-1:0]  data_arr [NASSOC][NBLOCK];
  logic [NASSOC-1:0]  valid    [NBLOCK];
  logic [WAY_W-1:0]   rr_ptr   [NBLOCK];

  logic [0:0]           state;
  logic [TAG_BIT-1:0]   base_tag;
  logic [INDEX_BIT-1:0] base_idx;
  logic [WAY_W-1:0]     victim_q;
  logic                 use_rr_q;
  logic                 flushed_q;
  logic [BEAT_W-1:0]    beat;
  logic [LINE_W-1:0]    line_buf;

  logic [TAG_BIT-1:0]   req_tag;
  logic [INDEX_BIT-1:0] req_idx;
  logic [OFS_W-1:0]     req_ofs;
  logic                 unused_addr;

  assign req_tag     = addr[31 -: TAG_BIT];
  assign req_idx     = addr[WORD_SELECT_BIT +: INDEX_BIT];
  assign req_ofs     = addr[WORD_SELECT_BIT-1:2];
  assign unused_addr = ^addr[1:0];

  logic              hit_raw;
  logic [WAY_W-1:0]  hit_way;
  logic [NASSOC-1:0] set_valid;
  logic              any_inv;
  logic [WAY_W-1:0]  inv_way;
  logic [LINE_W-1:0] hit_line;
  logic [31:0]       hit_word;
  logic              lookup, hit, miss;

  // Tag compare across all ways of the addressed set; lowest matching way wins.
  always_comb begin
    hit_raw = 1'b0;
    hit_way = '0;
    for (int w = NASSOC - 1; w >= 0; w--) begin
      if (valid[req_idx][w] && (tag_arr[w][req_idx] == req_tag)) begin
        hit_raw = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim search: lowest invalid way. A same-cycle flush makes the whole set count as invalid.
  always_comb begin
    set_valid = flush_i ? '0 : valid[req_idx];
    any_inv   = 1'b0;
    inv_way   = '0;
    for (int w = NASSOC - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Big-endian word assembly: byte at the lowest offset lands in the MSBs.
  always_comb begin
    hit_line = data_arr[hit_way][req_idx];
    hit_word = '0;
    for (int b = 0; b < 4; b++) begin
      hit_word[31 - 8*b -: 8] = hit_line[8*(4*int'(req_ofs) + b) +: 8];
    end
  end

  assign lookup   = (state == S_IDLE) && ce && read_flag;
  assign hit      = lookup && hit_raw && !flush_i;
  assign miss     = lookup && !(hit_raw && !flush_i);
  assign stallreq = miss || ((state == S_REFILL) && ce);

  logic              last_beat;
  logic              install;
  logic [LINE_W-1:0] fill_line;
  logic [WAY_W-1:0]  rr_next;

  assign last_beat = (beat == BEAT_W'(NBEAT - 1));
  assign install   = (state == S_REFILL) && cache_rep_i && last_beat && !flushed_q && !flush_i;
  assign rr_next   = (rr_ptr[base_idx] == WAY_W'(NASSOC - 1)) ? '0 : rr_ptr[base_idx] + WAY_W'(1);

  // Completed line: buffered beats plus the final beat arriving this cycle.
  always_comb begin
    fill_line = line_buf;
    fill_line[64*int'(beat) +: 64] = cache_rep_data_i;
  end

  // Refill FSM: latch base and victim on miss, walk beats on each reply, return to IDLE after the last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      cache_req_o  <= 1'b0;
      cache_addr_o <= '0;
      beat         <= '0;
      victim_q     <= '0;
      use_rr_q     <= 1'b0;
      flushed_q    <= 1'b0;
      base_tag     <= '0;
      base_idx     <= '0;
    end else if (state == S_IDLE) begin
      if (miss) begin
        state        <= S_REFILL;
        cache_req_o  <= 1'b1;
        cache_addr_o <= {req_tag, req_idx, {WORD_SELECT_BIT{1'b0}}};
        beat         <= '0;
        victim_q     <= any_inv ? inv_way : rr_ptr[req_idx];
        use_rr_q     <= !any_inv;
        flushed_q    <= 1'b0;
        base_tag     <= req_tag;
        base_idx     <= req_idx;
      end
    end else begin
      if (flush_i) flushed_q <= 1'b1;
      if (cache_rep_i) begin
        if (last_beat) begin
          state       <= S_IDLE;
          cache_req_o <= 1'b0;
        end else begin
          beat         <= beat + BEAT_W'(1);
          cache_addr_o <= cache_addr_o + 32'd8;
        end
      end
    end
  end

  // Beat capture into the line buffer while refilling.
  always_ff @(posedge clk) begin
    if ((state == S_REFILL) && cache_rep_i) line_buf[64*int'(beat) +: 64] <= cache_rep_data_i;
  end

  // Tag/data arrays: written only when a refill completes unflushed; never cleared.
  always_ff @(posedge clk) begin
    if (install) begin
      tag_arr[victim_q][base_idx]  <= base_tag;
      data_arr[victim_q][base_idx] <= fill_line;
    end
  end

  // Valid bits and RR pointers: flush wins over install; pointer moves only when a valid line was evicted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NBLOCK; i++) begin
        valid[i]  <= '0;
        rr_ptr[i] <= '0;
      end
    end else begin
      if (flush_i) begin
        for (int i = 0; i < NBLOCK; i++) valid[i] <= '0;
      end else if (install) begin
        valid[base_idx][victim_q] <= 1'b1;
      end
      if (install && use_rr_q) rr_ptr[base_idx] <= rr_next;
    end
  end

  // Fetch output register: hit data on lookup, zero when disabled, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      read_data <= '0;
    else if (!ce)  read_data <= '0;
    else if (hit)  read_data <= hit_word;
  end

`ifdef ICACHE_STATS_EN
  // Lookup statistics: hits per IDLE hit, misses per IDLE->REFILL transition; both wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (miss) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule
